// File: rtl/reg4_ctrl_pkg.sv
// Shared types and default sizing for the 4-byte register bank load sequencer.
package reg4_ctrl_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam int NBYTES_DEF = 4;
  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 8;

endpackage

// File: rtl/reg4_load_ctrl_byte_counter.sv
// Byte position counter: counts accepted bytes 0..NBYTES, flags the last slot.
module byte_counter #(
  parameter  int NBYTES = 4,
  localparam int CW     = $clog2(NBYTES) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holds at NBYTES once full; the word only restarts through clr_i.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_i && (cnt_q != CW'(NBYTES))) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(NBYTES - 1));

endmodule

// File: rtl/reg4_load_ctrl.sv
// Sequences a byte stream into the register bank, then offers the packed word downstream.
module reg4_load_ctrl
  import reg4_ctrl_pkg::*;
#(
  parameter  int NBYTES = NBYTES_DEF,
  parameter  int DW     = DW_DEF,
  parameter  int AW     = AW_DEF,
  localparam int CW     = $clog2(NBYTES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          reg_en,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_rst,
  output logic [CW-1:0] byte_cnt
);

  state_t state_q;
  state_t state_d;
  logic   hs;
  logic   last_slot;
  logic   cnt_clr;

  assign in_ready   = (state_q == S_LOAD) & ~flush;
  assign hs         = in_ready & in_valid;
  assign word_valid = (state_q == S_FULL);
  assign reg_rst    = (state_q == S_CLEAR);
  assign reg_en     = hs;
  assign reg_addr   = hs ? AW'(byte_cnt) : {AW{1'b0}};
  assign reg_wdata  = hs ? in_data : {DW{1'b0}};

  // Counter reads 0 throughout any clear cycle, including the one entered via flush or consume.
  assign cnt_clr = reg_rst | flush | (word_valid & word_ready);

  byte_counter #(.NBYTES(NBYTES)) u_byte_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .inc_i  (hs),
    .cnt_o  (byte_cnt),
    .tc_o   (last_slot)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: begin
        if (flush) state_d = S_CLEAR;
        else       state_d = S_LOAD;
      end
      S_LOAD: begin
        if (flush)                  state_d = S_CLEAR;
        else if (hs && last_slot)   state_d = S_FULL;
        else                        state_d = S_LOAD;
      end
      S_FULL: begin
        if (flush || word_ready) state_d = S_CLEAR;
        else                     state_d = S_FULL;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_reg4_load_ctrl.sv
// Bench for reg4_load_ctrl: vector table, reset/flush sequences and a randomized queue model.
module tb_reg4_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       word_valid;
  logic       word_ready;
  logic       reg_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_rst;
  logic [2:0] byte_cnt;

  int errors = 0;
  int checks = 0;

  reg4_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .reg_en     (reg_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rst    (reg_rst),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the register bank that sits beside the controller in the parent.
  logic [7:0]  bank_mem [4];
  logic [31:0] bank_word;
  always_ff @(posedge clk) begin
    if (reg_rst) begin
      for (int i = 0; i < 4; i++) bank_mem[i] <= 8'h00;
    end else if (reg_en) begin
      bank_mem[reg_addr[1:0]] <= reg_wdata;
    end
  end
  assign bank_word = {bank_mem[0], bank_mem[1], bank_mem[2], bank_mem[3]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: bytes collected so far, plus a flag for the one-cycle bank-clear bubble.
  logic [7:0] mq[$];
  bit         bubble;

  task automatic model_reset();
    mq.delete();
    bubble = 1'b1;
  endtask

  task automatic model_check();
    bit          rdy;
    bit          hs;
    logic [31:0] w;
    rdy = !bubble && (mq.size() < 4) && !flush;
    hs  = rdy && in_valid;
    chk("m_in_ready",   32'(in_ready),   32'(rdy));
    chk("m_word_valid", 32'(word_valid), 32'(!bubble && mq.size() == 4));
    chk("m_reg_rst",    32'(reg_rst),    32'(bubble));
    chk("m_reg_en",     32'(reg_en),     32'(hs));
    chk("m_byte_cnt",   32'(byte_cnt),   bubble ? 32'd0 : 32'(mq.size()));
    chk("m_reg_addr",   32'(reg_addr),   hs ? 32'(mq.size()) : 32'd0);
    chk("m_reg_wdata",  32'(reg_wdata),  hs ? 32'(in_data) : 32'd0);
    if (!bubble) begin
      w = 32'd0;
      for (int i = 0; i < mq.size(); i++) w[31-8*i -: 8] = mq[i];
      chk("m_bank", bank_word, w);
    end
  endtask

  task automatic model_update();
    if (bubble) begin
      mq.delete();
      bubble = flush;
    end else if (flush || (mq.size() == 4 && word_ready)) begin
      mq.delete();
      bubble = 1'b1;
    end else if (mq.size() < 4 && in_valid) begin
      mq.push_back(in_data);
    end
  endtask

  task automatic apply(input logic fl, input logic iv, input logic [7:0] d, input logic wr);
    flush = fl; in_valid = iv; in_data = d; word_ready = wr;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic fl, iv; logic [7:0] d; logic wr;
    logic ir, wv, en; logic [7:0] addr; logic [2:0] cnt; logic rr;
    logic cb; logic [31:0] word;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic fl, iv, input logic [7:0] d, input logic wr,
                      input logic ir, wv, en, input logic [7:0] addr, input logic [2:0] cnt,
                      input logic rr, cb, input logic [31:0] word);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.wr = wr; v.ir = ir; v.wv = wv; v.en = en;
    v.addr = addr; v.cnt = cnt; v.rr = rr; v.cb = cb; v.word = word;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; word_ready = 1'b0;
    model_reset();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      chk("rst_word_valid", 32'(word_valid), 32'd0);
      chk("rst_reg_en",     32'(reg_en),     32'd0);
      chk("rst_reg_addr",   32'(reg_addr),   32'd0);
      chk("rst_reg_wdata",  32'(reg_wdata),  32'd0);
      chk("rst_reg_rst",    32'(reg_rst),    32'd1);
      chk("rst_byte_cnt",   32'(byte_cnt),   32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // fl iv data wr | ir wv en addr cnt rr | chkbank word
    addv(0,1,8'h11,0, 0,0,0,8'd0,3'd0,1, 0,32'h0);
    addv(0,1,8'h11,0, 1,0,1,8'd0,3'd0,0, 1,32'h0);
    addv(0,1,8'h22,0, 1,0,1,8'd1,3'd1,0, 0,32'h0);
    addv(0,1,8'h33,0, 1,0,1,8'd2,3'd2,0, 0,32'h0);
    addv(0,1,8'h44,0, 1,0,1,8'd3,3'd3,0, 0,32'h0);
    for (int i = 0; i < 5; i++)
      addv(0,1,8'h55,0, 0,1,0,8'd0,3'd4,0, 1,32'h11223344);
    addv(0,1,8'h55,1, 0,1,0,8'd0,3'd4,0, 1,32'h11223344);
    addv(0,0,8'h00,0, 0,0,0,8'd0,3'd0,1, 0,32'h0);
    addv(0,0,8'h00,0, 1,0,0,8'd0,3'd0,0, 1,32'h0);
    addv(0,1,8'hA1,0, 1,0,1,8'd0,3'd0,0, 0,32'h0);
    addv(0,0,8'h00,0, 1,0,0,8'd0,3'd1,0, 0,32'h0);
    addv(0,0,8'h00,0, 1,0,0,8'd0,3'd1,0, 0,32'h0);
    addv(0,1,8'hA2,0, 1,0,1,8'd1,3'd1,0, 0,32'h0);
    addv(0,1,8'hA3,0, 1,0,1,8'd2,3'd2,0, 0,32'h0);
    addv(0,0,8'h00,0, 1,0,0,8'd0,3'd3,0, 0,32'h0);
    addv(0,1,8'hA4,0, 1,0,1,8'd3,3'd3,0, 0,32'h0);
    addv(0,0,8'h00,1, 0,1,0,8'd0,3'd4,0, 1,32'hA1A2A3A4);
    addv(0,0,8'h00,0, 0,0,0,8'd0,3'd0,1, 0,32'h0);
    addv(0,1,8'hAA,0, 1,0,1,8'd0,3'd0,0, 0,32'h0);
    addv(0,1,8'hBB,0, 1,0,1,8'd1,3'd1,0, 0,32'h0);
    addv(1,1,8'hCC,0, 0,0,0,8'd0,3'd2,0, 1,32'hAABB0000);
    addv(0,0,8'h00,0, 0,0,0,8'd0,3'd0,1, 0,32'h0);
    addv(0,1,8'h01,0, 1,0,1,8'd0,3'd0,0, 1,32'h0);
    addv(0,1,8'h02,0, 1,0,1,8'd1,3'd1,0, 0,32'h0);
    addv(0,1,8'h03,0, 1,0,1,8'd2,3'd2,0, 0,32'h0);
    addv(0,1,8'h04,0, 1,0,1,8'd3,3'd3,0, 0,32'h0);
    addv(0,0,8'h00,1, 0,1,0,8'd0,3'd4,0, 1,32'h01020304);
    addv(0,0,8'h00,0, 0,0,0,8'd0,3'd0,1, 0,32'h0);

    foreach (tbl[k]) begin
      apply(tbl[k].fl, tbl[k].iv, tbl[k].d, tbl[k].wr);
      chk($sformatf("v%0d_in_ready", k),   32'(in_ready),   32'(tbl[k].ir));
      chk($sformatf("v%0d_word_valid", k), 32'(word_valid), 32'(tbl[k].wv));
      chk($sformatf("v%0d_reg_en", k),     32'(reg_en),     32'(tbl[k].en));
      chk($sformatf("v%0d_reg_addr", k),   32'(reg_addr),   32'(tbl[k].addr));
      chk($sformatf("v%0d_byte_cnt", k),   32'(byte_cnt),   32'(tbl[k].cnt));
      chk($sformatf("v%0d_reg_rst", k),    32'(reg_rst),    32'(tbl[k].rr));
      if (tbl[k].en) chk($sformatf("v%0d_reg_wdata", k), 32'(reg_wdata), 32'(tbl[k].d));
      if (tbl[k].cb) chk($sformatf("v%0d_bank", k), bank_word, tbl[k].word);
      model_check();
      advance();
    end

    // Asynchronous reset after three bytes of a word.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 8'h71 + 8'(i), 1'b0);
      model_check();
      advance();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready",   32'(in_ready),   32'd0);
    chk("arst_word_valid", 32'(word_valid), 32'd0);
    chk("arst_reg_rst",    32'(reg_rst),    32'd1);
    chk("arst_byte_cnt",   32'(byte_cnt),   32'd0);
    chk("arst_reg_en",     32'(reg_en),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    model_check();
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 8'h81 + 8'(i), 1'b0);
      model_check();
      advance();
    end
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("arst_reload_bank", bank_word, 32'h81828384);
    chk("arst_reload_wv",   32'(word_valid), 32'd1);
    model_check();
    advance();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      apply(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            8'($urandom), ($urandom_range(2) == 0));
      model_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
